// File: rtl/node_port.sv
// rtl/node_port.sv - packet node port: outbound FIFO and flit serializer, inbound deserializer and packet queue
module node_port #(
  parameter int PKT_W     = 32,
  parameter int FLIT_W    = 8,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PKT_W-1:0]               pkt_in,
  input  logic                           pkt_in_avail,
  output logic                           cq_full,
  output logic [$clog2(OUT_DEPTH+1)-1:0] cq_count,
  input  logic                           free_outbound,
  output logic                           put_outbound,
  output logic [FLIT_W-1:0]              payload_outbound,
  input  logic                           put_inbound,
  output logic                           free_inbound,
  input  logic [FLIT_W-1:0]              payload_inbound,
  output logic [PKT_W-1:0]               pkt_out,
  output logic                           pkt_out_avail,
  input  logic                           pkt_out_ready,
  output logic                           err
);

  localparam int NFLITS = PKT_W / FLIT_W;
  localparam int OCW    = $clog2(OUT_DEPTH + 1);
  localparam int OPW    = $clog2(OUT_DEPTH);
  localparam int ICW    = $clog2(IN_DEPTH + 1);
  localparam int IPW    = $clog2(IN_DEPTH);
  localparam int FIW    = $clog2(NFLITS);

  localparam logic [OCW-1:0] O_FULL    = OCW'(OUT_DEPTH);
  localparam logic [ICW-1:0] I_FULL    = ICW'(IN_DEPTH);
  localparam logic [FIW-1:0] LAST_FLIT = FIW'(NFLITS - 1);

  generate
    if ((PKT_W % FLIT_W) != 0 || NFLITS < 2 ||
        OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 ||
        IN_DEPTH < 2 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_bad_params
      $error("node_port: illegal parameter combination");
    end
  endgenerate

  // ---------------------------------------------------------------- outbound

  typedef enum logic {O_IDLE, O_SEND} o_state_t;

  o_state_t         o_state, o_state_n;
  logic [PKT_W-1:0] o_mem [OUT_DEPTH];
  logic [OPW-1:0]   o_wr, o_rd;
  logic [OCW-1:0]   o_cnt;
  logic [PKT_W-1:0] o_shift;
  logic [FIW-1:0]   o_idx;
  logic             o_push, o_drop, o_pop, o_last;

  assign cq_count = o_cnt;
  assign cq_full  = (o_cnt == O_FULL);
  // fullness is judged before any same-cycle pop, so a push into a full FIFO is always lost
  assign o_push   = pkt_in_avail & ~cq_full;
  assign o_drop   = pkt_in_avail & cq_full;

  // outbound state register
  always_ff @(posedge clk) begin
    if (rst) o_state <= O_IDLE;
    else     o_state <= o_state_n;
  end

  // outbound next state: free_outbound only matters while idle
  always_comb begin
    o_state_n = o_state;
    o_pop     = 1'b0;
    o_last    = 1'b0;
    case (o_state)
      O_IDLE: begin
        if (o_cnt != '0 && free_outbound) begin
          o_pop     = 1'b1;
          o_state_n = O_SEND;
        end
      end
      O_SEND: begin
        if (o_idx == LAST_FLIT) begin
          o_last    = 1'b1;
          o_state_n = O_IDLE;
        end
      end
      default: o_state_n = O_IDLE;
    endcase
  end

  // outbound packet storage
  always_ff @(posedge clk) begin
    if (!rst && o_push) o_mem[o_wr] <= pkt_in;
  end

  // outbound pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr  <= '0;
      o_rd  <= '0;
      o_cnt <= '0;
    end else begin
      if (o_push) o_wr <= o_wr + OPW'(1);
      if (o_pop)  o_rd <= o_rd + OPW'(1);
      case ({o_push, o_pop})
        2'b10:   o_cnt <= o_cnt + OCW'(1);
        2'b01:   o_cnt <= o_cnt - OCW'(1);
        default: o_cnt <= o_cnt;
      endcase
    end
  end

  // serializer: flit 0 leaves with the pop, the rest shift out LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      o_shift          <= '0;
      o_idx            <= '0;
      put_outbound     <= 1'b0;
      payload_outbound <= '0;
    end else if (o_pop) begin
      o_shift          <= o_mem[o_rd] >> FLIT_W;
      o_idx            <= '0;
      put_outbound     <= 1'b1;
      payload_outbound <= o_mem[o_rd][FLIT_W-1:0];
    end else if (o_state == O_SEND) begin
      if (o_last) begin
        put_outbound     <= 1'b0;
        payload_outbound <= '0;
      end else begin
        o_shift          <= o_shift >> FLIT_W;
        o_idx            <= o_idx + FIW'(1);
        payload_outbound <= o_shift[FLIT_W-1:0];
      end
    end
  end

  // ----------------------------------------------------------------- inbound

  typedef enum logic {I_IDLE, I_RECV} i_state_t;

  i_state_t         i_state, i_state_n;
  logic [PKT_W-1:0] i_mem [IN_DEPTH];
  logic [IPW-1:0]   i_wr, i_rd;
  logic [ICW-1:0]   i_cnt, i_cnt_n;
  logic [PKT_W-1:0] i_asm, i_asm_n;
  logic [FIW-1:0]   i_idx, i_idx_n;
  logic             i_push, i_pop, i_proto_err, free_n;

  assign pkt_out_avail = (i_cnt != '0);
  assign pkt_out       = pkt_out_avail ? i_mem[i_rd] : '0;

  // inbound state register and assembly buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= I_IDLE;
      i_asm   <= '0;
      i_idx   <= '0;
    end else begin
      i_state <= i_state_n;
      i_asm   <= i_asm_n;
      i_idx   <= i_idx_n;
    end
  end

  // inbound next state, flit capture, queue occupancy and ready look-ahead
  always_comb begin
    i_state_n   = i_state;
    i_asm_n     = i_asm;
    i_idx_n     = i_idx;
    i_push      = 1'b0;
    i_proto_err = 1'b0;
    case (i_state)
      I_IDLE: begin
        if (put_inbound) begin
          if (free_inbound) begin
            i_asm_n                = '0;
            i_asm_n[FLIT_W-1:0]    = payload_inbound;
            i_idx_n                = FIW'(1);
            i_state_n              = I_RECV;
          end else begin
            i_proto_err = 1'b1;
          end
        end
      end
      I_RECV: begin
        if (put_inbound) begin
          i_asm_n[int'(i_idx)*FLIT_W +: FLIT_W] = payload_inbound;
          if (i_idx == LAST_FLIT) begin
            i_push    = 1'b1;
            i_idx_n   = '0;
            i_state_n = I_IDLE;
          end else begin
            i_idx_n = i_idx + FIW'(1);
          end
        end else begin
          // a gap in the flit train loses the partial packet
          i_proto_err = 1'b1;
          i_idx_n     = '0;
          i_state_n   = I_IDLE;
        end
      end
      default: i_state_n = I_IDLE;
    endcase

    i_pop   = pkt_out_avail & pkt_out_ready;
    i_cnt_n = i_cnt;
    case ({i_push, i_pop})
      2'b10:   i_cnt_n = i_cnt + ICW'(1);
      2'b01:   i_cnt_n = i_cnt - ICW'(1);
      default: i_cnt_n = i_cnt;
    endcase
    // a packet is only accepted if it is guaranteed a queue slot on completion
    free_n = (i_state_n == I_IDLE) && (i_cnt_n != I_FULL);
  end

  // inbound packet storage
  always_ff @(posedge clk) begin
    if (!rst && i_push) i_mem[i_wr] <= i_asm_n;
  end

  // inbound pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      i_wr         <= '0;
      i_rd         <= '0;
      i_cnt        <= '0;
      free_inbound <= 1'b0;
    end else begin
      if (i_push) i_wr <= i_wr + IPW'(1);
      if (i_pop)  i_rd <= i_rd + IPW'(1);
      i_cnt        <= i_cnt_n;
      free_inbound <= free_n;
    end
  end

  // sticky error flag
  always_ff @(posedge clk) begin
    if (rst)                        err <= 1'b0;
    else if (o_drop || i_proto_err) err <= 1'b1;
  end

endmodule
